// File: rtl/bcdu_instr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bcdu_instr_arbiter
// Description : Round-robin, burst-locking arbiter that shares the BCDU
//               instruction port behind a registered valid/ready output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module bcdu_instr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*INSTR_WIDTH-1:0] i_req_instr,
    input  logic [NUM_REQ-1:0]             i_req_last,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic                           o_bcdu_instr_valid,
    output logic [INSTR_WIDTH-1:0]         o_bcdu_instr,
    input  logic                           i_bcdu_ready,
    output logic [$clog2(NUM_REQ)-1:0]     o_grant_id,
    output logic                           o_busy
);

    localparam int c_GRANT_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                   r_state;
    logic [c_GRANT_W-1:0]     r_grant_id;
    logic                     r_out_valid;
    logic [INSTR_WIDTH-1:0]   r_out_instr;

    logic [INSTR_WIDTH-1:0]   w_req_instr [NUM_REQ];
    logic                     w_found;
    logic [c_GRANT_W-1:0]     w_next_grant;
    logic                     w_out_free;
    logic                     w_accept;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_instr[gi] = i_req_instr[gi*INSTR_WIDTH +: INSTR_WIDTH];
        end
    endgenerate

    // Walk offsets from the far end so the nearest valid requester after the
    // previous grant is the one left standing.
    always_comb begin
        int idx;
        w_found      = 1'b0;
        w_next_grant = r_grant_id;
        idx          = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = int'(r_grant_id) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (i_req_valid[c_GRANT_W'(idx)]) begin
                w_found      = 1'b1;
                w_next_grant = c_GRANT_W'(idx);
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign w_out_free = !r_out_valid || i_bcdu_ready;
    assign w_accept   = (r_state == ST_LOCKED) && w_out_free && i_req_valid[r_grant_id];

    always_comb begin
        o_req_ready = '0;
        if ((r_state == ST_LOCKED) && w_out_free) begin
            o_req_ready[r_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_grant_id  <= c_GRANT_W'(NUM_REQ - 1);
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_LOCKED;
                        r_grant_id <= w_next_grant;
                    end
                end
                ST_LOCKED: begin
                    if (w_accept && i_req_last[r_grant_id]) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_req_instr[r_grant_id];
            end else if (i_bcdu_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_bcdu_instr_valid = r_out_valid;
    assign o_bcdu_instr       = r_out_instr;
    assign o_grant_id         = r_grant_id;
    assign o_busy             = (r_state == ST_LOCKED) || r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_bcdu_instr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcdu_instr_arbiter
// Description : Directed scenarios plus randomized bursts against a
//               transaction-level round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcdu_instr_arbiter;

    localparam int NR = 4;
    localparam int IW = 16;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [NR-1:0]     i_req_valid;
    logic [NR*IW-1:0]  i_req_instr;
    logic [NR-1:0]     i_req_last;
    logic [NR-1:0]     o_req_ready;
    logic              o_bcdu_instr_valid;
    logic [IW-1:0]     o_bcdu_instr;
    logic              i_bcdu_ready;
    logic [1:0]        o_grant_id;
    logic              o_busy;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    bcdu_instr_arbiter #(.NUM_REQ(NR), .INSTR_WIDTH(IW)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_req_valid        (i_req_valid),
        .i_req_instr        (i_req_instr),
        .i_req_last         (i_req_last),
        .o_req_ready        (o_req_ready),
        .o_bcdu_instr_valid (o_bcdu_instr_valid),
        .o_bcdu_instr       (o_bcdu_instr),
        .i_bcdu_ready       (i_bcdu_ready),
        .o_grant_id         (o_grant_id),
        .o_busy             (o_busy)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input int k, input logic v, input logic [IW-1:0] instr, input logic l);
        i_req_valid[k]          = v;
        i_req_instr[k*IW +: IW] = instr;
        i_req_last[k]           = l;
    endtask

    task automatic do_reset();
        i_rst        = 1'b1;
        i_req_valid  = '0;
        i_req_instr  = '0;
        i_req_last   = '0;
        i_bcdu_ready = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    function automatic logic [IW-1:0] mk(input int k, input int b, input int bt);
        return {k[3:0], b[7:0], bt[3:0]};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (o_bcdu_instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_bcdu_instr_valid); end
        checks++; if (o_bcdu_instr !== 16'h0) begin errors++; $display("FAIL reset_instr: got %h want 0000", o_bcdu_instr); end
        checks++; if (o_req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", o_req_ready); end
        checks++; if (o_grant_id !== 2'd3) begin errors++; $display("FAIL reset_grant: got %0d want 3", o_grant_id); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_single_beat();
        do_reset();
        drive(1, 1'b1, 16'h2300, 1'b1);
        #1;
        checks++; if (o_req_ready !== 4'b0) begin errors++; $display("FAIL single_idle_ready: got %b want 0000", o_req_ready); end
        tick();
        #1;
        checks++; if (o_req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b want 0010", o_req_ready); end
        checks++; if (o_grant_id !== 2'd1) begin errors++; $display("FAIL single_grant: got %0d want 1", o_grant_id); end
        checks++; if (o_bcdu_instr_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", o_bcdu_instr_valid); end
        tick();
        drive(1, 1'b0, 16'h0, 1'b0);
        #1;
        checks++; if (!(o_bcdu_instr_valid === 1'b1 && o_bcdu_instr === 16'h2300)) begin errors++; $display("FAIL single_out: got v=%b %h want v=1 2300", o_bcdu_instr_valid, o_bcdu_instr); end
        checks++; if (o_req_ready !== 4'b0) begin errors++; $display("FAIL single_back_idle: got %b want 0000", o_req_ready); end
        tick();
        #1;
        checks++; if (o_bcdu_instr_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL single_drain: got v=%b busy=%b want 0 0", o_bcdu_instr_valid, o_busy); end
    endtask

    task automatic test_burst_lock();
        logic [IW-1:0] beats [3];
        beats[0] = 16'h1000; beats[1] = 16'h1001; beats[2] = 16'h1002;
        drive(2, 1'b1, beats[0], 1'b0);
        drive(0, 1'b1, 16'h0AAA, 1'b1);
        tick();
        #1;
        checks++; if (o_grant_id !== 2'd2 || o_req_ready !== 4'b0100) begin errors++; $display("FAIL burst_grant: got g=%0d r=%b want g=2 r=0100", o_grant_id, o_req_ready); end
        for (int b = 0; b < 3; b++) begin
            tick();
            if (b < 2) drive(2, 1'b1, beats[b+1], (b == 1));
            else       drive(2, 1'b0, 16'h0, 1'b0);
            #1;
            checks++; if (!(o_bcdu_instr_valid === 1'b1 && o_bcdu_instr === beats[b])) begin errors++; $display("FAIL burst_beat%0d: got v=%b %h want v=1 %h", b, o_bcdu_instr_valid, o_bcdu_instr, beats[b]); end
            checks++; if (o_req_ready !== ((b < 2) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL burst_lock_ready%0d: got %b", b, o_req_ready); end
        end
        tick();
        #1;
        checks++; if (o_grant_id !== 2'd0 || o_req_ready !== 4'b0001) begin errors++; $display("FAIL burst_next_grant: got g=%0d r=%b want g=0 r=0001", o_grant_id, o_req_ready); end
        tick();
        drive(0, 1'b0, 16'h0, 1'b0);
        #1;
        checks++; if (o_bcdu_instr !== 16'h0AAA) begin errors++; $display("FAIL burst_req0_out: got %h want 0aaa", o_bcdu_instr); end
        tick();
    endtask

    task automatic test_round_robin();
        int got [6];
        int expd [6];
        int ng;
        expd = '{0, 1, 3, 0, 1, 3};
        ng = 0;
        do_reset();
        drive(0, 1'b1, 16'h5000, 1'b1);
        drive(1, 1'b1, 16'h5101, 1'b1);
        drive(3, 1'b1, 16'h5303, 1'b1);
        for (int cyc = 0; cyc < 40 && ng < 6; cyc++) begin
            #1;
            for (int k = 0; k < NR; k++) begin
                if (o_req_ready[k] && i_req_valid[k]) begin
                    got[ng] = k;
                    ng++;
                end
            end
            tick();
        end
        i_req_valid = '0;
        checks++; if (ng != 6) begin errors++; $display("FAIL rr_timeout: got %0d grants want 6", ng); end
        for (int i = 0; i < ng; i++) begin
            checks++; if (got[i] != expd[i]) begin errors++; $display("FAIL rr_order%0d: got %0d want %0d", i, got[i], expd[i]); end
        end
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(0, 1'b1, 16'h3001, 1'b0);
        tick();
        #1;
        checks++; if (o_req_ready !== 4'b0001) begin errors++; $display("FAIL bp_ready: got %b want 0001", o_req_ready); end
        tick();
        drive(0, 1'b1, 16'h3002, 1'b1);
        i_bcdu_ready = 1'b0;
        #1;
        checks++; if (o_req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready: got %b want 0000", o_req_ready); end
        for (int s = 0; s < 3; s++) begin
            tick();
            if (s == 2) i_bcdu_ready = 1'b1;
            #1;
            checks++; if (!(o_bcdu_instr_valid === 1'b1 && o_bcdu_instr === 16'h3001)) begin errors++; $display("FAIL bp_hold%0d: got v=%b %h want v=1 3001", s, o_bcdu_instr_valid, o_bcdu_instr); end
            checks++; if (o_req_ready !== ((s == 2) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL bp_gate%0d: got %b", s, o_req_ready); end
        end
        tick();
        drive(0, 1'b0, 16'h0, 1'b0);
        #1;
        checks++; if (!(o_bcdu_instr_valid === 1'b1 && o_bcdu_instr === 16'h3002)) begin errors++; $display("FAIL bp_second: got v=%b %h want v=1 3002", o_bcdu_instr_valid, o_bcdu_instr); end
        tick();
        #1;
        checks++; if (o_bcdu_instr_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got v=%b want 0", o_bcdu_instr_valid); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        drive(1, 1'b1, 16'h4001, 1'b0);
        tick();
        tick();
        drive(1, 1'b1, 16'h4002, 1'b0);
        #1;
        checks++; if (!(o_bcdu_instr_valid === 1'b1 && o_bcdu_instr === 16'h4001)) begin errors++; $display("FAIL rst_pre: got v=%b %h want v=1 4001", o_bcdu_instr_valid, o_bcdu_instr); end
        i_rst = 1'b1;
        tick();
        checks++; if (o_bcdu_instr_valid !== 1'b0 || o_bcdu_instr !== 16'h0) begin errors++; $display("FAIL rst_out: got v=%b %h want v=0 0000", o_bcdu_instr_valid, o_bcdu_instr); end
        checks++; if (o_req_ready !== 4'b0 || o_grant_id !== 2'd3 || o_busy !== 1'b0) begin errors++; $display("FAIL rst_state: got r=%b g=%0d busy=%b want 0000 3 0", o_req_ready, o_grant_id, o_busy); end
        i_rst = 1'b0;
        drive(1, 1'b1, 16'h4101, 1'b1);
        tick();
        #1;
        checks++; if (o_bcdu_instr_valid !== 1'b0 || o_req_ready !== 4'b0010) begin errors++; $display("FAIL rst_restart_arb: got v=%b r=%b want 0 0010", o_bcdu_instr_valid, o_req_ready); end
        tick();
        drive(1, 1'b0, 16'h0, 1'b0);
        #1;
        checks++; if (!(o_bcdu_instr_valid === 1'b1 && o_bcdu_instr === 16'h4101)) begin errors++; $display("FAIL rst_restart_out: got v=%b %h want v=1 4101", o_bcdu_instr_valid, o_bcdu_instr); end
        tick();
    endtask

    // Every requester with work left always presents a beat, so the expected
    // stream is plain round-robin over requesters with bursts remaining.
    task automatic test_random(input int run);
        int nb [NR];
        int bl [NR][8];
        int cb [NR];
        int cbt [NR];
        int rem [NR];
        logic [IW-1:0] exp_q [$];
        logic [IW-1:0] expv;
        logic [NR-1:0] acc;
        logic [3:0] mask;
        int last_g;
        int nxt;
        bit finished;
        do_reset();
        mask = 4'($urandom_range(1, 15));
        if ($countones(mask) < 2) mask = 4'b1111;
        for (int k = 0; k < NR; k++) begin
            nb[k]  = mask[k] ? int'($urandom_range(2, 6)) : 0;
            cb[k]  = 0;
            cbt[k] = 0;
            rem[k] = nb[k];
            for (int b = 0; b < 8; b++) bl[k][b] = int'($urandom_range(1, 4));
        end
        last_g = NR - 1;
        do begin
            nxt = -1;
            for (int s = 1; s <= NR; s++) begin
                if (nxt < 0 && rem[(last_g + s) % NR] > 0) nxt = (last_g + s) % NR;
            end
            if (nxt >= 0) begin
                for (int bt = 0; bt < bl[nxt][nb[nxt] - rem[nxt]]; bt++)
                    exp_q.push_back(mk(nxt, nb[nxt] - rem[nxt], bt));
                rem[nxt]--;
                last_g = nxt;
            end
        end while (nxt >= 0);

        acc = '0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            for (int k = 0; k < NR; k++) begin
                if (acc[k]) begin
                    if (cbt[k] == bl[k][cb[k]] - 1) begin cb[k]++; cbt[k] = 0; end
                    else cbt[k]++;
                end
            end
            for (int k = 0; k < NR; k++) begin
                if (cb[k] < nb[k])
                    drive(k, (cbt[k] == 0) ? 1'b1 : ($urandom_range(0, 3) != 0),
                          mk(k, cb[k], cbt[k]), (cbt[k] == bl[k][cb[k]] - 1));
                else
                    drive(k, 1'b0, 16'h0, 1'b0);
            end
            i_bcdu_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (!$onehot0(o_req_ready)) begin errors++; $display("FAIL rnd%0d_onehot: got %b", run, o_req_ready); end
            acc = i_req_valid & o_req_ready;
            if (o_bcdu_instr_valid && i_bcdu_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd%0d_extra: got %h want nothing", run, o_bcdu_instr);
                end else begin
                    expv = exp_q.pop_front();
                    if (o_bcdu_instr !== expv) begin errors++; $display("FAIL rnd%0d_data: got %h want %h", run, o_bcdu_instr, expv); end
                end
            end
            tick();
            if (exp_q.size() == 0) finished = 1'b1;
        end
        checks++; if (!finished) begin errors++; $display("FAIL rnd%0d_timeout: got %0d beats pending want 0", run, exp_q.size()); end
        i_req_valid = '0;
        i_req_last  = '0;
        i_bcdu_ready = 1'b1;
        tick();
        tick();
        checks++; if (o_bcdu_instr_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle: got v=%b busy=%b want 0 0", run, o_bcdu_instr_valid, o_busy); end
    endtask

    initial begin
        i_rst        = 1'b1;
        i_req_valid  = '0;
        i_req_instr  = '0;
        i_req_last   = '0;
        i_bcdu_ready = 1'b1;
        test_reset();
        test_single_beat();
        test_burst_lock();
        test_round_robin();
        test_backpressure();
        test_reset_mid_burst();
        for (int r = 0; r < 3; r++) test_random(r);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
